// File: rtl/bbox_pkg.sv
// rtl/bbox_pkg.sv - shared types and channel constants for the bounding-box finder/writer pair
package bbox_pkg;
  typedef logic [10:0] coord_t;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  localparam int CH_PER_PIX = 3;
endpackage

// File: rtl/bbox_rect_walker.sv
// rtl/bbox_rect_walker.sv - row-major (x,y,ch) sequencer over a rectangle outline or fill
module bbox_rect_walker
  import bbox_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       advance_i,
  input  logic       fill_i,
  input  coord_t     xmin_i,
  input  coord_t     xmax_i,
  input  coord_t     ymin_i,
  input  coord_t     ymax_i,
  output coord_t     x_o,
  output coord_t     y_o,
  output logic [1:0] ch_o,
  output logic       last_o
);
  coord_t     x_q, x_d, y_q, y_d;
  logic [1:0] ch_q, ch_d;
  logic       interior_row;

  assign interior_row = (y_q != ymin_i) && (y_q != ymax_i);
  assign last_o = (ch_q == CH_B) && (x_q == xmax_i) && (y_q == ymax_i);

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    ch_d = ch_q;
    if (load_i) begin
      x_d  = xmin_i;
      y_d  = ymin_i;
      ch_d = CH_R;
    end else if (advance_i) begin
      if (ch_q != CH_B) begin
        ch_d = ch_q + 2'd1;
      end else begin
        ch_d = CH_R;
        if (x_q == xmax_i) begin
          x_d = xmin_i;
          y_d = y_q + 11'd1;
        end else if (interior_row && !fill_i) begin
          // Interior rows only own their two edge pixels; skip straight across.
          x_d = xmax_i;
        end else begin
          x_d = x_q + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      ch_q <= CH_R;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      ch_q <= ch_d;
    end
  end

  assign x_o  = x_q;
  assign y_o  = y_q;
  assign ch_o = ch_q;
endmodule

// File: rtl/bbox_outline_writer.sv
// rtl/bbox_outline_writer.sv - paints a clamped box outline into RGB memory, one byte per cycle
// Optional BBOX_FILL_EN adds a fill port that paints the whole rectangle.
module bbox_outline_writer
  import bbox_pkg::*;
#(
  parameter int          WIDTH     = 100,
  parameter int          HEIGHT    = 100,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  input  logic [10:0] xMin,
  input  logic [10:0] xMax,
  input  logic [10:0] yMin,
  input  logic [10:0] yMax,
  input  logic [23:0] colour,
`ifdef BBOX_FILL_EN
  input  logic        fill,
`endif
  output logic [31:0] addr,
  output logic [15:0] wrdata,
  output logic        wren
);
  localparam logic [31:0] ROW_BYTES = 32'(WIDTH * CH_PER_PIX);

  state_t      state_q, state_d;
  coord_t      xmin_q, xmax_q, ymin_q, ymax_q;
  logic [23:0] colour_q;
  logic        fill_q, fill_w;
  coord_t      xmax_c, ymax_c, xmin_w, xmax_w, ymin_w, ymax_w, x, y;
  logic [1:0]  ch;
  logic        load, last, empty;

  assign xmax_c = (xMax > coord_t'(WIDTH - 1))  ? coord_t'(WIDTH - 1)  : xMax;
  assign ymax_c = (yMax > coord_t'(HEIGHT - 1)) ? coord_t'(HEIGHT - 1) : yMax;
  assign empty  = (xMin > xmax_c) || (yMin > ymax_c);

  // The walker sees the incoming box on the load cycle, the latched box afterwards.
  assign xmin_w = load ? xMin   : xmin_q;
  assign xmax_w = load ? xmax_c : xmax_q;
  assign ymin_w = load ? yMin   : ymin_q;
  assign ymax_w = load ? ymax_c : ymax_q;

`ifdef BBOX_FILL_EN
  assign fill_w = fill_q;
`else
  assign fill_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = empty ? DONE : WRITE;
        end
      end
      WRITE:   if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      colour_q <= '0;
      fill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        xmin_q   <= xMin;
        xmax_q   <= xmax_c;
        ymin_q   <= yMin;
        ymax_q   <= ymax_c;
        colour_q <= colour;
`ifdef BBOX_FILL_EN
        fill_q   <= fill;
`else
        fill_q   <= 1'b0;
`endif
      end
    end
  end

  bbox_rect_walker u_walker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .advance_i (state_q == WRITE),
    .fill_i    (fill_w),
    .xmin_i    (xmin_w),
    .xmax_i    (xmax_w),
    .ymin_i    (ymin_w),
    .ymax_i    (ymax_w),
    .x_o       (x),
    .y_o       (y),
    .ch_o      (ch),
    .last_o    (last)
  );

  assign wren = (state_q == WRITE);
  assign done = (state_q == DONE);
  assign addr = BASE_ADDR + 32'(y) * ROW_BYTES + 32'(x) * 32'(CH_PER_PIX) + 32'(ch);

  always_comb begin
    wrdata = 16'h0000;
    case (ch)
      CH_R:    wrdata = {8'h00, colour_q[23:16]};
      CH_G:    wrdata = {8'h00, colour_q[15:8]};
      default: wrdata = {8'h00, colour_q[7:0]};
    endcase
  end
endmodule

// File: tb/tb_bbox_outline_writer.sv
// tb/tb_bbox_outline_writer.sv - directed self-checking bench for bbox_outline_writer
module tb_bbox_outline_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [10:0] xMin = '0, xMax = '0, yMin = '0, yMax = '0;
  logic [23:0] colour = '0;
  logic        fill = 1'b0;
  logic [31:0] addr;
  logic [15:0] wrdata;
  logic        wren;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_addr[$];
  int exp_data[$];
  int max_addr;
  int first_addr;
  int hit_6333;

  bbox_outline_writer #(.WIDTH(100), .HEIGHT(100), .BASE_ADDR(32'd0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .done   (done),
    .xMin   (xMin),
    .xMax   (xMax),
    .yMin   (yMin),
    .yMax   (yMax),
    .colour (colour),
`ifdef BBOX_FILL_EN
    .fill   (fill),
`endif
    .addr   (addr),
    .wrdata (wrdata),
    .wren   (wren)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Reference: scan every pixel of the clamped box and keep the ones the spec paints.
  task automatic build_expected(input int xa, input int xb, input int ya, input int yb,
                                input int col, input bit fl);
    int cxb, cyb;
    exp_addr.delete();
    exp_data.delete();
    cxb = (xb > 99) ? 99 : xb;
    cyb = (yb > 99) ? 99 : yb;
    for (int yy = ya; yy <= cyb; yy++)
      for (int xx = xa; xx <= cxb; xx++)
        if (fl || yy == ya || yy == cyb || xx == xa || xx == cxb)
          for (int c = 0; c < 3; c++) begin
            exp_addr.push_back(yy * 300 + xx * 3 + c);
            exp_data.push_back((col >> (16 - 8 * c)) & 8'hFF);
          end
  endtask

  task automatic run_pass(input string tag, input int xa, input int xb, input int ya,
                          input int yb, input int col, input bit fl);
    int n, cyc, done_cyc;
    build_expected(xa, xb, ya, yb, col, fl);
    @(negedge clk);
    xMin = 11'(xa); xMax = 11'(xb); yMin = 11'(ya); yMax = 11'(yb);
    colour = 24'(col); fill = fl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_latency"}, {31'd0, wren}, {31'd0, exp_addr.size() > 0});
    n = 0; cyc = 0; done_cyc = -1; max_addr = 0; first_addr = -1; hit_6333 = 0;
    while (cyc < 2000) begin
      if (done) begin done_cyc = cyc; break; end
      if (wren) begin
        if (first_addr < 0) first_addr = int'(addr);
        if (int'(addr) > max_addr) max_addr = int'(addr);
        if (addr >= 32'd6333 && addr <= 32'd6335) hit_6333 = 1;
        if (n < exp_addr.size()) begin
          if (addr !== 32'(exp_addr[n]) || wrdata !== 16'(exp_data[n])) begin
            check({tag, "_addr"}, addr, 32'(exp_addr[n]));
            check({tag, "_data"}, {16'd0, wrdata}, 32'(exp_data[n]));
          end
        end
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_writes"}, 32'(n), 32'(exp_addr.size()));
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_addr.size()));
  endtask

  initial begin
    @(negedge clk);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_wren",   {31'd0, wren}, 32'd0);
    check("rst_addr",   addr, 32'd0);
    check("rst_wrdata", {16'd0, wrdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_pass("t1", 10, 12, 20, 22, 24'hFF0000, 1'b0);
    check("t1_first_addr", 32'(first_addr), 32'd6030);
    check("t1_interior_untouched", 32'(hit_6333), 32'd0);

    run_pass("t2", 5, 5, 5, 5, 24'h123456, 1'b0);
    check("t2_first_addr", 32'(first_addr), 32'd1515);

    run_pass("t3", 99, 0, 99, 0, 24'hABCDEF, 1'b0);

    run_pass("t4", 90, 120, 95, 130, 24'h00FF00, 1'b0);
    check("t4_count", 32'(exp_addr.size()), 32'd78);
    check("t4_max_addr", 32'(max_addr), 32'd29999);

    run_pass("vline", 7, 7, 3, 6, 24'h0102FF, 1'b0);
    run_pass("hline", 2, 6, 4, 4, 24'h808080, 1'b0);
    run_pass("w2", 40, 41, 10, 14, 24'h0A0B0C, 1'b0);
    run_pass("repeat", 10, 12, 20, 22, 24'hFF0000, 1'b0);

    // Abort mid-pass: reset after the 7th write must kill wren immediately.
    begin
      int n, cyc;
      @(negedge clk);
      xMin = 11'd10; xMax = 11'd12; yMin = 11'd20; yMax = 11'd22;
      colour = 24'hFF0000; fill = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0; cyc = 0;
      while (n < 7 && cyc < 100) begin
        if (wren) n++;
        if (n < 7) @(negedge clk);
        cyc++;
      end
      check("t5_reached_7", 32'(n), 32'd7);
      rst_n = 1'b0;
      #1;
      check("t5_wren_async", {31'd0, wren}, 32'd0);
      check("t5_done_async", {31'd0, done}, 32'd0);
      check("t5_addr_async", addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    run_pass("t5_repaint", 10, 12, 20, 22, 24'hFF0000, 1'b0);

`ifdef BBOX_FILL_EN
    run_pass("t6", 0, 2, 0, 2, 24'h445566, 1'b1);
    check("t6_count", 32'(exp_addr.size()), 32'd27);
    run_pass("t6_again", 0, 2, 0, 2, 24'h445566, 1'b1);
    run_pass("t6_fill0", 0, 3, 0, 3, 24'h445566, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
